// File: rtl/vector_op_sched.sv
// Vector op sequencer: sweeps BRAM A/B, emits element-wise words or one reduction word.
// Latency: READ_LAT+1 cycles per element. Stalls in OUT while out_ready is low; nothing is queued.
// Optional: define VECOP_EUC_EN to support opcode 7 (squared Euclidean distance).
module vector_op_sched #(
    parameter int N_ELEM   = 1024,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 10,
    parameter int READ_LAT = 1,
    parameter int ACC_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [7:0]        cmd,
    output logic [ADDR_W-1:0] bram_a_read_addr,
    output logic [ADDR_W-1:0] bram_b_read_addr,
    input  logic [DATA_W-1:0] bram_a_dout,
    input  logic [DATA_W-1:0] bram_b_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam logic [2:0] OP_SUM  = 3'd3;
    localparam logic [2:0] OP_AVG  = 3'd4;
    localparam logic [2:0] OP_DIFF = 3'd5;
    localparam logic [2:0] OP_DOT  = 3'd6;
    localparam logic [2:0] OP_EUC  = 3'd7;
    localparam int WCNT_W = (READ_LAT > 1) ? $clog2(READ_LAT + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CAPTURE, S_OUT, S_DONE} state_t;

    state_t              state, next_state;
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   idx;
    logic [WCNT_W-1:0]   wait_cnt;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    term;
    logic [DATA_W:0]     sum_w;
    logic [DATA_W-1:0]   diff_w;
    logic [2*DATA_W-1:0] prod_w;
    logic                op_ok, op_bad, wait_done, last_idx, is_red;
    logic                unused_cmd_bits;

    assign unused_cmd_bits  = ^cmd[7:3];
    assign bram_a_read_addr = idx;
    assign bram_b_read_addr = idx;
    assign wait_done        = (wait_cnt == WCNT_W'(READ_LAT - 1));
    assign last_idx         = (idx == ADDR_W'(N_ELEM - 1));
    assign is_red           = (op_q == OP_DOT) || (op_q == OP_EUC);

    always_comb begin
        op_ok  = 1'b0;
        op_bad = 1'b0;
        case (cmd[2:0])
            OP_SUM, OP_AVG, OP_DIFF, OP_DOT: op_ok = 1'b1;
`ifdef VECOP_EUC_EN
            OP_EUC: op_ok = 1'b1;
`else
            OP_EUC: op_bad = 1'b1;
`endif
            default: op_ok = 1'b0;
        endcase
    end

    // Element terms at full width, zero-extended into the accumulator width.
`ifdef VECOP_EUC_EN
    logic [2*DATA_W-1:0] sq_w;
    assign sq_w = (2*DATA_W)'(diff_w) * (2*DATA_W)'(diff_w);
`endif
    always_comb begin
        sum_w  = {1'b0, bram_a_dout} + {1'b0, bram_b_dout};
        diff_w = (bram_a_dout >= bram_b_dout) ? (bram_a_dout - bram_b_dout)
                                              : (bram_b_dout - bram_a_dout);
        prod_w = (2*DATA_W)'(bram_a_dout) * (2*DATA_W)'(bram_b_dout);
        term   = '0;
        case (op_q)
            OP_SUM:  term = ACC_W'(sum_w);
            OP_AVG:  term = ACC_W'(sum_w >> 1);
            OP_DIFF: term = ACC_W'(diff_w);
            OP_DOT:  term = ACC_W'(prod_w);
`ifdef VECOP_EUC_EN
            OP_EUC:  term = ACC_W'(sq_w);
`endif
            default: term = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (cmd_valid && op_ok) next_state = S_WAIT;
            S_WAIT:    if (wait_done) next_state = S_CAPTURE;
            S_CAPTURE: next_state = (!is_red || last_idx) ? S_OUT : S_WAIT;
            S_OUT:     if (out_ready) next_state = out_last ? S_DONE : S_WAIT;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        out_valid = (state == S_OUT);
        done      = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            idx      <= '0;
            wait_cnt <= '0;
            acc      <= '0;
            out_data <= '0;
            out_last <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && op_ok) begin
                        op_q     <= cmd[2:0];
                        idx      <= '0;
                        wait_cnt <= '0;
                    end
                    err <= cmd_valid && op_bad;
                end
                S_WAIT: if (!wait_done) wait_cnt <= wait_cnt + 1'b1;
                S_CAPTURE: begin
                    wait_cnt <= '0;
                    if (!is_red) begin
                        out_data <= term;
                        out_last <= last_idx;
                    end else if (last_idx) begin
                        out_data <= acc + term;
                        out_last <= 1'b1;
                    end else begin
                        acc <= acc + term;
                        idx <= idx + 1'b1;
                    end
                end
                S_OUT: if (out_ready && !out_last) idx <= idx + 1'b1;
                S_DONE: begin
                    acc      <= '0;
                    idx      <= '0;
                    out_last <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_op_sched.sv
// Randomized self-checking bench for vector_op_sched with a 4-entry BRAM model.
module tb_vector_op_sched;
    localparam int N = 4;
    localparam int RL = 1;

    logic        clk, reset, cmd_valid, out_valid, out_ready, out_last, busy, done, err;
    logic [7:0]  cmd;
    logic [9:0]  bram_a_read_addr, bram_b_read_addr, bram_a_dout, bram_b_dout;
    logic [31:0] out_data;
    logic [9:0]  mem_a [N];
    logic [9:0]  mem_b [N];

    int checks = 0;
    int errors = 0;

    longint exp_q[$], got_q[$];
    bit     last_q[$];
    int     addr_q[$], rise_q[$], hs_q[$];
    int     first_valid, done_cnt, done_cyc, err_cnt, unstable, addr_mismatch, stall_seen;
    bit     busy0, timed_out;

    vector_op_sched #(.N_ELEM(N), .ADDR_W(10), .DATA_W(10), .READ_LAT(RL), .ACC_W(32)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .bram_a_read_addr(bram_a_read_addr), .bram_b_read_addr(bram_b_read_addr),
        .bram_a_dout(bram_a_dout), .bram_b_dout(bram_b_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        bram_a_dout <= mem_a[bram_a_read_addr[1:0]];
        bram_b_dout <= mem_b[bram_b_read_addr[1:0]];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, required summary before time limit");
        $fatal(1, "watchdog expired");
    end

    // Reference results straight from the opcode definitions.
    function automatic void build_exp(input int op);
        longint acc = 0;
        longint a, b;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            a = longint'(mem_a[i]);
            b = longint'(mem_b[i]);
            case (op)
                3: exp_q.push_back(a + b);
                4: exp_q.push_back((a + b) / 2);
                5: exp_q.push_back(a > b ? a - b : b - a);
                6: acc += a * b;
                7: acc += (a - b) * (a - b);
                default: ;
            endcase
        end
        if (op >= 6) exp_q.push_back(acc & 64'hFFFF_FFFF);
    endfunction

    task automatic load_fixed();
        mem_a[0] = 10'd1; mem_a[1] = 10'd2; mem_a[2] = 10'd3; mem_a[3] = 10'd1023;
        mem_b[0] = 10'd5; mem_b[1] = 10'd2; mem_b[2] = 10'd1; mem_b[3] = 10'd1023;
    endtask

    // Issues a command and records what the DUT does until it returns to idle.
    task automatic run_cmd(input logic [7:0] c, input int stall_idx, input int stall_len,
                           input bit rand_rdy, input int inj_cyc, input logic [7:0] inj_cmd);
        int cyc = 0;
        int stalled = 0;
        bit prev_stall = 0;
        bit prev_valid = 0;
        bit rdy;
        logic [31:0] prev_data = '0;
        got_q.delete(); last_q.delete(); addr_q.delete(); rise_q.delete(); hs_q.delete();
        first_valid = -1; done_cnt = 0; done_cyc = -1; err_cnt = 0; unstable = 0;
        addr_mismatch = 0; stall_seen = 0; timed_out = 1; busy0 = 0;
        @(negedge clk); cmd = c; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        while (cyc < 400) begin
            if (cyc == 0) busy0 = busy;
            if (err) err_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (out_valid && !prev_valid) begin
                rise_q.push_back(cyc);
                if (first_valid < 0) first_valid = cyc;
            end
            if (prev_stall && out_data !== prev_data) unstable++;
            if (bram_a_read_addr !== bram_b_read_addr) addr_mismatch++;
            if (cyc > 0 && !busy && !done) begin timed_out = 0; break; end
            cmd_valid = (cyc == inj_cyc);
            if (cyc == inj_cyc) cmd = inj_cmd;
            if (rand_rdy) rdy = ($urandom_range(0, 1) == 1);
            else rdy = !(out_valid && got_q.size() == stall_idx && stalled < stall_len);
            if (!rand_rdy && out_valid && !rdy) stalled++;
            out_ready = rdy;
            if (out_valid && rdy) begin
                got_q.push_back(longint'(out_data));
                last_q.push_back(out_last);
                addr_q.push_back(int'(bram_a_read_addr));
                hs_q.push_back(cyc + 1);
            end
            prev_stall = out_valid && !rdy;
            prev_data  = out_data;
            prev_valid = out_valid;
            @(negedge clk);
            cyc++;
        end
        stall_seen = stalled;
        cmd_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        checks++; if ({out_last, busy, done, err} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {out_last, busy, done, err}); end
        checks++; if ({bram_a_read_addr, bram_b_read_addr} !== 20'd0) begin errors++; $display("FAIL reset_addr: got %0d/%0d want 0/0", bram_a_read_addr, bram_b_read_addr); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sum();
        load_fixed(); build_exp(3);
        run_cmd(8'hF3, -1, 0, 0, -1, 8'h00);
        checks++; if (timed_out) begin errors++; $display("FAIL sum_timeout: got no idle return, want return within budget"); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL sum_busy_from_accept: got %b want 1", busy0); end
        checks++; if (got_q.size() != N) begin errors++; $display("FAIL sum_count: got %0d want %0d", got_q.size(), N); end
        for (int i = 0; i < got_q.size() && i < N; i++) begin
            checks++; if (got_q[i] != exp_q[i] || last_q[i] != (i == N - 1) || addr_q[i] != i) begin
                errors++; $display("FAIL sum_word%0d: got data %0d last %0b addr %0d want %0d %0b %0d", i, got_q[i], last_q[i], addr_q[i], exp_q[i], i == N - 1, i);
            end
        end
        checks++; if (first_valid != RL + 1) begin errors++; $display("FAIL sum_first_latency: got %0d want %0d", first_valid, RL + 1); end
        for (int i = 1; i < rise_q.size() && i <= hs_q.size(); i++) begin
            checks++; if (rise_q[i] != hs_q[i-1] + RL + 1) begin errors++; $display("FAIL sum_next_latency%0d: got %0d want %0d", i, rise_q[i], hs_q[i-1] + RL + 1); end
        end
        checks++; if (done_cnt != 1 || hs_q.size() == 0 || done_cyc != hs_q[hs_q.size()-1]) begin
            errors++; $display("FAIL sum_done: got %0d pulses at %0d want 1 pulse right after final handshake", done_cnt, done_cyc);
        end
        checks++; if (addr_mismatch != 0) begin errors++; $display("FAIL sum_addr_equal: got %0d mismatches want 0", addr_mismatch); end
    endtask

    task automatic test_diff_stall();
        load_fixed(); build_exp(5);
        run_cmd(8'h05, 1, 5, 0, -1, 8'h00);
        checks++; if (got_q != exp_q) begin errors++; $display("FAIL diff_words: got %p want %p", got_q, exp_q); end
        checks++; if (stall_seen != 5) begin errors++; $display("FAIL diff_stall_len: got %0d want 5", stall_seen); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL diff_stable: got %0d changes want 0", unstable); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL diff_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reduction();
        load_fixed(); build_exp(6);
        run_cmd(8'h06, -1, 0, 0, -1, 8'h00);
        checks++; if (got_q != exp_q || last_q.size() != 1 || last_q[0] != 1'b1) begin
            errors++; $display("FAIL dot_word: got %p last %p want %p last 1", got_q, last_q, exp_q);
        end
        checks++; if (first_valid != N * (RL + 1)) begin errors++; $display("FAIL dot_latency: got %0d want %0d", first_valid, N * (RL + 1)); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL dot_done: got %0d want 1", done_cnt); end
`ifdef VECOP_EUC_EN
        build_exp(7);
        run_cmd(8'h07, -1, 0, 0, -1, 8'h00);
        checks++; if (got_q != exp_q || last_q.size() != 1 || last_q[0] != 1'b1) begin
            errors++; $display("FAIL euc_word: got %p want %p", got_q, exp_q);
        end
        checks++; if (first_valid != N * (RL + 1)) begin errors++; $display("FAIL euc_latency: got %0d want %0d", first_valid, N * (RL + 1)); end
`else
        @(negedge clk); cmd = 8'h07; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL euc_off_err: got err %b busy %b want 1 0", err, busy); end
        @(negedge clk);
        checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL euc_off_pulse: got err %b busy %b want 0 0", err, busy); end
`endif
    endtask

    task automatic test_ignored_cmds();
        int seen = 0;
        @(negedge clk); cmd = 8'h02; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        repeat (3) begin
            if (err || busy) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL op2_ignored: got %0d active cycles want 0", seen); end
        load_fixed(); build_exp(3);
        run_cmd(8'h03, -1, 0, 0, 1, 8'h06);
        checks++; if (got_q != exp_q) begin errors++; $display("FAIL busy_ignore_a: got %p want %p", got_q, exp_q); end
        run_cmd(8'h03, -1, 0, 0, 4, 8'h07);
        checks++; if (got_q != exp_q || err_cnt != 0 || done_cnt != 1) begin
            errors++; $display("FAIL busy_ignore_b: got %p err %0d done %0d want %p 0 1", got_q, err_cnt, done_cnt, exp_q);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int stray = 0;
        load_fixed();
        @(negedge clk); cmd = 8'h03; cmd_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk); cmd_valid = 1'b0;
        while (k < 20 && !out_valid) begin @(negedge clk); k++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_reach_out: got %b want 1", out_valid); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({out_valid, out_last, busy, done, err} !== 5'b0 || out_data !== 32'd0 || bram_a_read_addr !== 10'd0) begin
            errors++; $display("FAIL rst_mid_outputs: got v%b l%b b%b d%b e%b data %0d addr %0d want all 0",
                               out_valid, out_last, busy, done, err, out_data, bram_a_read_addr);
        end
        reset = 1'b0; out_ready = 1'b1;
        repeat (5) begin
            if (done || busy || out_valid) stray++;
            @(negedge clk);
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", stray); end
        build_exp(3);
        run_cmd(8'h03, -1, 0, 0, -1, 8'h00);
        checks++; if (got_q != exp_q || addr_q.size() == 0 || addr_q[0] != 0) begin
            errors++; $display("FAIL rst_mid_rerun: got %p want %p from element 0", got_q, exp_q);
        end
    endtask

    task automatic test_random();
        int ops[$] = '{3, 4, 5, 6};
        int op;
        logic [4:0] hi;
`ifdef VECOP_EUC_EN
        ops.push_back(7);
`endif
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < N; i++) begin
                mem_a[i] = 10'($urandom_range(0, 1023));
                mem_b[i] = 10'($urandom_range(0, 1023));
            end
            op = ops[$urandom_range(0, ops.size() - 1)];
            hi = 5'($urandom);
            build_exp(op);
            run_cmd({hi, 3'(op)}, -1, 0, 1, -1, 8'h00);
            checks++; if (got_q != exp_q || timed_out || done_cnt != 1 || unstable != 0) begin
                errors++; $display("FAIL random%0d_op%0d: got %p done %0d unstable %0d want %p done 1 unstable 0",
                                   t, op, got_q, done_cnt, unstable, exp_q);
            end
            for (int i = 0; i < last_q.size(); i++) begin
                checks++; if (last_q[i] != (i == exp_q.size() - 1)) begin
                    errors++; $display("FAIL random%0d_last%0d: got %0b want %0b", t, i, last_q[i], i == exp_q.size() - 1);
                end
            end
        end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd = 8'h00; out_ready = 1'b1; reset = 1'b1;
        load_fixed();
        test_reset();
        test_sum();
        test_diff_stall();
        test_reduction();
        test_ignored_cmds();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
